alu_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational `alu` instance between `NREQ` requesters. Each requester presents operands and an opcode with a valid/ready handshake. The block grants one requester, drives the shared ALU from registered operands, and captures the result into a register. It then returns the result with the requester's ID on a single valid/ready response channel. The block sits between the issue-side clients and the `alu`, which is instantiated beside it and connected through the `alu_*` ports.

---
 rtl/alu_share_arb.sv | 157 +++++++++++++++
 tb/tb_alu_share_arb.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one ALU between NREQ requesters.
// Ports: req_* valid/ready in, rsp_* valid/ready out, alu_* to/from ALU.
module alu_share_arb #(
  parameter int WIDTH = 8,
  parameter int OPC   = 3,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*OPC-1:0]   req_ctrl,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  busy,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [OPC-1:0]        alu_ctrl,
  input  logic [WIDTH-1:0]      alu_result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   prio_q, prio_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPC-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  logic [OPC-1:0]   c_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    assign c_arr[i] = req_ctrl[i*OPC +: OPC];
  end

  logic           grant_any;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;
  int             idx;

  // Circular search starting at prio_q; first valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(prio_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // rst_n gates the grant so it clears the instant reset asserts.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == S_IDLE && grant_any)
      req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_valid_d  = rsp_valid_q;
    busy_d       = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          alu_a_d    = a_arr[grant_idx];
          alu_b_d    = b_arr[grant_idx];
          alu_ctrl_d = c_arr[grant_idx];
          rsp_id_d   = grant_idx;
          prio_d     = (grant_idx == IDW'(NREQ-1))
                     ? '0 : grant_idx + IDW'(1);
          busy_d     = 1'b1;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_result_d = alu_result;
        rsp_valid_d  = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      prio_q       <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_valid  = rsp_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Testbench for alu_share_arb: directed scenarios plus random traffic
// checked against a transaction-level model; ALU stub is a ^ b.
module tb_alu_share_arb;
  localparam int W = 8;
  localparam int O = 3;
  localparam int N = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*O-1:0] req_ctrl;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_result;
  logic           busy;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [O-1:0]   alu_ctrl;
  logic [W-1:0]   alu_result;

  always #5 clk = ~clk;

  assign alu_result = alu_a ^ alu_b;

  alu_share_arb #(.WIDTH(W), .OPC(O), .NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int grant_log[$];
  int rsp_log[$];
  logic [N-1:0] last_rdy;

  // transaction-level model
  int       m_prio;
  bit       m_busy;
  int       m_age;
  int       m_id;
  int       m_res;
  int       m_a, m_b, m_c;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prio = 0; m_busy = 0; m_age = 0;
    m_id = 0; m_res = 0;
    m_a = 0; m_b = 0; m_c = 0;
  endtask

  task automatic set_req(input int i, input bit v, input int a,
                         input int b, input int c);
    req_valid[i] = v;
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
    req_ctrl[i*O +: O] = O'(c);
  endtask

  // One clock: check against model, clock, advance model.
  task automatic cycle();
    int w;
    logic [N-1:0] er;
    bit ev;
    bit rr;
    int sa, sb, sc;
    #1;
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && req_valid[(m_prio + k) % N]) w = (m_prio + k) % N;
    er = '0;
    if (!m_busy && w >= 0) er[w] = 1'b1;
    ev = m_busy && m_age >= 1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("alu_a", 32'(alu_a), m_a);
    chk("alu_b", 32'(alu_b), m_b);
    chk("alu_ctrl", 32'(alu_ctrl), m_c);
    if (ev) begin
      chk("rsp_id", 32'(rsp_id), m_id);
      chk("rsp_result", 32'(rsp_result), m_res);
    end
    rr = rsp_ready;
    if (w >= 0) begin
      sa = int'(req_a[w*W +: W]);
      sb = int'(req_b[w*W +: W]);
      sc = int'(req_ctrl[w*O +: O]);
    end else begin
      sa = 0; sb = 0; sc = 0;
    end
    @(posedge clk);
    if (er != '0) begin
      m_busy = 1; m_age = 0; m_id = w;
      m_a = sa; m_b = sb; m_c = sc;
      m_res = sa ^ sb;
      m_prio = (w + 1) % N;
      grant_log.push_back(w);
    end else if (m_busy) begin
      if (ev && rr) begin
        m_busy = 0;
        rsp_log.push_back(cyc);
      end else begin
        m_age++;
      end
    end
    last_rdy = er;
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    grant_log.delete();
    rsp_log.delete();
  endtask

  initial begin
    logic [IW-1:0] sid;
    logic [W-1:0] sres;
    int cnt;
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_ctrl = '0;
    rsp_ready = 1'b0;
    last_rdy = '0;
    model_reset();

    // reset state
    #2;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_rsp_result", 32'(rsp_result), 0);
    do_reset();

    // single request from requester 2
    set_req(2, 1, 10, 5, 3);
    #1 chk("single_ready", 32'(req_ready), 32'h4);
    cycle();
    req_valid[2] = 1'b0;
    chk("single_alu_a", 32'(alu_a), 10);
    chk("single_alu_b", 32'(alu_b), 5);
    chk("single_alu_ctrl", 32'(alu_ctrl), 3);
    cycle();
    chk("single_rsp_valid", 32'(rsp_valid), 1);
    chk("single_rsp_id", 32'(rsp_id), 2);
    chk("single_rsp_result", 32'(rsp_result), 15);
    rsp_ready = 1'b1;
    cycle();
    chk("single_idle_busy", 32'(busy), 0);

    // all four valid continuously
    do_reset();
    for (int i = 0; i < N; i++)
      set_req(i, 1, $urandom_range(255), $urandom_range(255),
              $urandom_range(7));
    rsp_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      cycle();
      for (int i = 0; i < N; i++)
        if (last_rdy[i])
          set_req(i, 1, $urandom_range(255), $urandom_range(255),
                  $urandom_range(7));
    end
    chk("rr_grants", 32'(grant_log.size() >= 5), 1);
    chk("rr_rsps", 32'(rsp_log.size() >= 5), 1);
    if (grant_log.size() >= 5 && rsp_log.size() >= 5) begin
      for (int k = 0; k < 5; k++)
        chk("rr_order", grant_log[k], k % N);
      for (int k = 1; k < 5; k++)
        chk("rr_spacing", rsp_log[k] - rsp_log[k-1], 3);
    end

    // backpressure
    do_reset();
    set_req(1, 1, 8'h3c, 8'ha5, 5);
    cycle();
    req_valid[1] = 1'b0;
    set_req(0, 1, 8'h11, 8'h22, 1);
    cycle();
    sid = rsp_id;
    sres = rsp_result;
    chk("bp_id", 32'(sid), 1);
    chk("bp_result", 32'(sres), 32'h99);
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valid", 32'(rsp_valid), 1);
      chk("bp_hold_id", 32'(rsp_id), 32'(sid));
      chk("bp_hold_result", 32'(rsp_result), 32'(sres));
      chk("bp_hold_ready", 32'(req_ready), 0);
      cycle();
    end
    rsp_ready = 1'b1;
    cycle();
    chk("bp_next_grant", 32'(req_ready), 32'h1);
    cycle();
    req_valid[0] = 1'b0;
    cycle();
    cycle();

    // priority wrap: prio becomes 3 after serving requester 2
    do_reset();
    rsp_ready = 1'b1;
    set_req(2, 1, 1, 2, 0);
    cycle();
    req_valid[2] = 1'b0;
    cycle();
    cycle();
    grant_log.delete();
    set_req(3, 1, 7, 9, 2);
    set_req(0, 1, 4, 4, 6);
    for (int c = 0; c < 6; c++) begin
      cycle();
      req_valid = req_valid & ~last_rdy;
    end
    set_req(1, 1, 8'hf0, 8'h0f, 7);
    for (int c = 0; c < 4; c++) begin
      cycle();
      req_valid = req_valid & ~last_rdy;
    end
    chk("wrap_count", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      chk("wrap_first", grant_log[0], 3);
      chk("wrap_second", grant_log[1], 0);
      chk("wrap_third", grant_log[2], 1);
    end

    // reset during EXEC
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1, 8'h55, 8'h0f, 4);
    cycle();
    chk("mid_busy_pre", 32'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_req_ready", 32'(req_ready), 0);
    chk("mid_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_rsp_id", 32'(rsp_id), 0);
    chk("mid_rsp_result", 32'(rsp_result), 0);
    chk("mid_alu_a", 32'(alu_a), 0);
    chk("mid_alu_b", 32'(alu_b), 0);
    chk("mid_alu_ctrl", 32'(alu_ctrl), 0);
    model_reset();
    req_valid = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) cycle();
    grant_log.delete();
    for (int i = 0; i < N; i++) set_req(i, 1, i, 3 * i, i);
    cycle();
    chk("mid_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    req_valid = '0;
    for (int c = 0; c < 3; c++) cycle();

    // requester 1 withdraws while 0 is served
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 1, 8'h81, 8'h18, 3);
    set_req(1, 1, 8'h42, 8'h24, 2);
    cycle();
    req_valid = '0;
    for (int c = 0; c < 6; c++) cycle();
    cnt = 0;
    foreach (grant_log[k]) if (grant_log[k] == 1) cnt++;
    chk("withdraw_no_grant1", cnt, 0);
    chk("withdraw_grants", grant_log.size(), 1);

    // random traffic
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (last_rdy[i])
          req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(2) == 0)
          set_req(i, 1, $urandom_range(255), $urandom_range(255),
                  $urandom_range(7));
        else if (req_valid[i] && $urandom_range(19) == 0)
          req_valid[i] = 1'b0;
      end
      rsp_ready = 1'($urandom_range(1));
      cycle();
    end
    chk("rand_activity", 32'(rsp_log.size() > 50), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
